// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED shift-register driver.
//   led_sr_state_t : frame sequencer states (IDLE, SETUP, CLK_HI, LATCH)
//   LED_WIDTH      : default number of LED bits per frame
//   LED_SR_CLK_DIV : default HCLK cycles per shift-clock phase
//   led_cnt_w()    : width of a counter that must hold 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        CLK_HI = 2'd2,
        LATCH  = 2'd3
    } led_sr_state_t;

    localparam int LED_WIDTH      = 8;
    localparam int LED_SR_CLK_DIV = 4;

    // A 1-entry range still needs a 1-bit counter, hence the floor of 1.
    function automatic int led_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_sr_phase_timer.sv
// -----------------------------------------------------------------------------
// led_sr_phase_timer
// Counts HCLK cycles within one shift-clock phase, 0..CLK_DIV-1.
// Ports:
//   i_clk          : HCLK
//   i_rst_n        : asynchronous active-low reset
//   i_clear        : restart the phase at 0 on the next edge (state change)
//   o_phase_done   : high in the last cycle of the phase
// -----------------------------------------------------------------------------
module led_sr_phase_timer
    import led_pkg::*;
#(
    parameter int CLK_DIV = LED_SR_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_phase_done
);

    localparam int              CW   = led_cnt_w(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_phase_cnt;

    assign o_phase_done = (r_phase_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase_cnt <= '0;
        end else if (i_clear || o_phase_done) begin
            r_phase_cnt <= '0;
        end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_shift_driver.sv
// -----------------------------------------------------------------------------
// led_shift_driver
// Serialises the LED register value onto a 74HC595-style shift register.
// A frame is sent after reset and whenever led_in differs from the value last
// delivered. Each bit is a SETUP phase (SRCLK low, SER valid) followed by a
// CLK_HI phase (SRCLK high); after the last bit RCLK is pulsed for one phase.
//
// Optional macro LED_SR_REFRESH_EN: adds a free-running REFRESH_CYCLES counter
// that forces a re-send of the current value on every terminal count.
//
// Ports:
//   HCLK     : system clock
//   HRESETn  : asynchronous active-low reset, applies to every flop
//   led_in   : parallel LED value (WIDTH bits), synchronous to HCLK
//   sr_data  : SER pin
//   sr_clk   : SRCLK pin (external register samples on the rising edge)
//   sr_latch : RCLK pin (high pulse transfers the register to the LEDs)
//   busy     : high while a frame is in flight
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------
module led_shift_driver
    import led_pkg::*;
#(
    parameter int WIDTH          = LED_WIDTH,
    parameter int CLK_DIV        = LED_SR_CLK_DIV,
    parameter int MSB_FIRST      = 1,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] led_in,
    output logic             sr_data,
    output logic             sr_clk,
    output logic             sr_latch,
    output logic             busy
);

    localparam int            BW      = led_cnt_w(WIDTH);
    localparam logic [BW-1:0] TOP_IDX = BW'(WIDTH - 1);

    led_sr_state_t    r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_sent_val;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_force_pending;
    logic             r_sr_data;
    logic             r_sr_clk;
    logic             r_sr_latch;
    logic             r_busy;

    logic             w_phase_done;
    logic             w_start;
    logic             w_state_change;
    logic             w_refresh_tc;

    // bit_cnt counts down from WIDTH-1; the shift order decides which bit of
    // the frozen value that count selects.
    function automatic logic pick_bit(input logic [WIDTH-1:0] v,
                                      input logic [BW-1:0]    cnt);
        logic [BW-1:0] idx;
        idx = (MSB_FIRST != 0) ? cnt : (TOP_IDX - cnt);
        return v[idx];
    endfunction

    assign w_start        = (led_in != r_sent_val) || r_force_pending;
    assign w_state_change = (r_state == IDLE) ? w_start : w_phase_done;

    led_sr_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .i_clk        (HCLK),
        .i_rst_n      (HRESETn),
        .i_clear      (w_state_change),
        .o_phase_done (w_phase_done)
    );

`ifdef LED_SR_REFRESH_EN
    localparam int            RW      = led_cnt_w(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_TOP = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] r_refresh_cnt;

    assign w_refresh_tc = (r_refresh_cnt == REF_TOP);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_refresh_cnt <= '0;
        end else if (w_refresh_tc) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end
`else
    // The refresh period only matters when the refresh counter is built.
    localparam int unused_refresh_cycles = REFRESH_CYCLES;

    assign w_refresh_tc = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state         <= IDLE;
            r_shadow        <= '0;
            r_sent_val      <= '0;
            r_bit_cnt       <= '0;
            r_force_pending <= 1'b1;
            r_sr_data       <= 1'b0;
            r_sr_clk        <= 1'b0;
            r_sr_latch      <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shadow        <= led_in;
                        r_bit_cnt       <= TOP_IDX;
                        r_force_pending <= 1'b0;
                        r_busy          <= 1'b1;
                        // SER must already be valid during the first SETUP.
                        r_sr_data       <= pick_bit(led_in, TOP_IDX);
                        r_sr_clk        <= 1'b0;
                        r_state         <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_phase_done) begin
                        r_sr_clk <= 1'b1;
                        r_state  <= CLK_HI;
                    end
                end
                CLK_HI: begin
                    if (w_phase_done) begin
                        r_sr_clk <= 1'b0;
                        if (r_bit_cnt == '0) begin
                            r_sr_latch <= 1'b1;
                            r_state    <= LATCH;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            r_sr_data <= pick_bit(r_shadow, r_bit_cnt - 1'b1);
                            r_state   <= SETUP;
                        end
                    end
                end
                LATCH: begin
                    if (w_phase_done) begin
                        r_sr_latch <= 1'b0;
                        r_sent_val <= r_shadow;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // A terminal count wins over the clear on frame start so that a
            // tick landing mid-frame (or on the start edge) is never lost.
            if (w_refresh_tc) begin
                r_force_pending <= 1'b1;
            end
        end
    end

    assign sr_data  = r_sr_data;
    assign sr_clk   = r_sr_clk;
    assign sr_latch = r_sr_latch;
    assign busy     = r_busy;

endmodule

// File: tb/tb_led_shift_driver.sv
module tb_led_shift_driver;

    localparam int WIDTH   = 8;
    localparam int CLK_DIV = 4;
`ifdef LED_SR_REFRESH_EN
    localparam int REFRESH = 200;
`else
    localparam int REFRESH = 1000;
`endif
    localparam int FRAME_BUSY = (2 * WIDTH + 1) * CLK_DIV;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [WIDTH-1:0] led_in;
    logic             sr_data, sr_clk, sr_latch, busy;

    led_shift_driver #(
        .WIDTH          (WIDTH),
        .CLK_DIV        (CLK_DIV),
        .MSB_FIRST      (1),
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .led_in   (led_in),
        .sr_data  (sr_data),
        .sr_clk   (sr_clk),
        .sr_latch (sr_latch),
        .busy     (busy)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- 74HC595 model and frame observer ----------------
    typedef struct packed {
        logic [7:0]  val;
        logic [31:0] edges;
        logic [31:0] latch_len;
        logic [31:0] busy_len;
    } frame_t;

    frame_t     frames[$];
    int         starts[$];
    int         cyc = 0;
    int         total_edges = 0;
    logic [7:0] sr595 = '0;
    logic [7:0] out595 = '0;
    logic       p_clk = 0, p_latch = 0, p_busy = 0;
    int         e_cnt = 0, l_len = 0, b_len = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            p_clk = 0; p_latch = 0; p_busy = 0;
            e_cnt = 0; l_len = 0; b_len = 0;
        end else begin
            if (sr_clk && !p_clk) begin
                sr595 = {sr595[6:0], sr_data};
                e_cnt++;
                total_edges++;
            end
            if (sr_latch && !p_latch) out595 = sr595;
            if (sr_latch) l_len++;
            if (busy) b_len++;
            if (busy && !p_busy) starts.push_back(cyc);
            if (!busy && p_busy) begin
                frames.push_back('{out595, e_cnt, l_len, b_len});
                e_cnt = 0; l_len = 0; b_len = 0;
            end
            p_clk = sr_clk; p_latch = sr_latch; p_busy = busy;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t get_frame(input int i);
        frame_t f;
        f = '{8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        if (i < frames.size()) f = frames[i];
        return f;
    endfunction

    function automatic int get_start(input int i);
        if (i < starts.size()) return starts[i];
        return -1;
    endfunction

    task automatic wait_frames(input string tag, input int want, input int bound);
        int k = 0;
        while (frames.size() < want && k < bound) begin
            @(posedge HCLK);
            k++;
        end
        check(tag, 32'(frames.size() >= want), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int i, input logic [7:0] exp_val);
        frame_t f;
        f = get_frame(i);
        check({tag, "_val"},   32'(f.val),  32'(exp_val));
        check({tag, "_edges"}, f.edges,     32'(WIDTH));
        check({tag, "_busy"},  f.busy_len,  32'(FRAME_BUSY));
        check({tag, "_latch"}, f.latch_len, 32'(CLK_DIV));
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        logic [7:0] last;
        logic [7:0] v;
        int         exp_n;
        int         e0;
        int         k;

`ifdef LED_SR_REFRESH_EN
        led_in  = 8'h5A;
`else
        led_in  = 8'h00;
`endif
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_sr_data",  32'(sr_data),  32'd0);
        check("rst_sr_clk",   32'(sr_clk),   32'd0);
        check("rst_sr_latch", 32'(sr_latch), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);

        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check("post_rst_busy_rise", 32'(busy), 32'd1);

`ifdef LED_SR_REFRESH_EN
        // Constant value: frames must recur once per refresh period.
        wait_frames("refresh_wait", 4, 1200);
        for (int i = 0; i < 4; i++) check_frame("refresh_frame", i, 8'h5A);
        for (int i = 0; i < 3; i++)
            check("refresh_period", 32'(get_start(i + 1) - get_start(i)), 32'(REFRESH));
`else
        wait_frames("post_rst_wait", 1, 200);
        check_frame("post_rst", 0, 8'h00);
        last = 8'h00;

        // MSB-first 0xA5 through the 595 model.
        @(negedge HCLK);
        led_in = 8'hA5;
        @(posedge HCLK);
        #1;
        check("a5_busy_rise", 32'(busy), 32'd1);
        wait_frames("a5_wait", 2, 200);
        check_frame("a5", 1, 8'hA5);
        last = 8'hA5;

        // Changes during a frame are ignored; only the newest follows.
        @(negedge HCLK);
        led_in = 8'h3C;
        repeat (5) @(negedge HCLK);
        led_in = 8'hC3;
        repeat (5) @(negedge HCLK);
        led_in = 8'hFF;
        wait_frames("chg_wait", 4, 400);
        check_frame("chg_first", 2, 8'h3C);
        check_frame("chg_second", 3, 8'hFF);
        check("chg_back_to_back", 32'(get_start(3) - get_start(2)), 32'(FRAME_BUSY + 1));
        repeat (150) @(posedge HCLK);
        check("chg_no_extra", 32'(frames.size()), 32'd4);
        last = 8'hFF;

        // Re-writing the delivered value must not start a frame.
        e0 = total_edges;
        @(negedge HCLK);
        led_in = 8'hFF;
        repeat (20) @(posedge HCLK);
        #1;
        check("same_busy_a", 32'(busy), 32'd0);
        @(negedge HCLK);
        led_in = 8'hFF;
        repeat (80) @(posedge HCLK);
        #1;
        check("same_busy_b", 32'(busy), 32'd0);
        check("same_no_edges", 32'(total_edges), 32'(e0));
        check("same_no_frame", 32'(frames.size()), 32'd4);

        // Randomized values against the "deliver latest distinct value" rule.
        exp_n = frames.size();
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom_range(0, 255));
            if (i == 2) v = last;
            @(negedge HCLK);
            led_in = v;
            repeat (100) @(posedge HCLK);
            if (v != last) begin
                exp_n++;
                last = v;
            end
            check("rand_count", 32'(frames.size()), 32'(exp_n));
            check("rand_val", 32'(get_frame(exp_n - 1).val), 32'(last));
        end

        // Reset in the middle of the SETUP phase of bit 3.
        exp_n = frames.size();
        @(negedge HCLK);
        led_in = 8'h0F;
        k = 0;
        while (!busy && k < 20) begin
            @(posedge HCLK);
            #1;
            k++;
        end
        check("midrst_busy", 32'(busy), 32'd1);
        repeat (33) @(posedge HCLK);
        #1;
        check("midrst_pre_clk",  32'(sr_clk),  32'd0);
        check("midrst_pre_data", 32'(sr_data), 32'd1);
        #3;
        HRESETn = 1'b0;
        #1;
        check("midrst_sr_clk",   32'(sr_clk),   32'd0);
        check("midrst_sr_latch", 32'(sr_latch), 32'd0);
        check("midrst_sr_data",  32'(sr_data),  32'd0);
        check("midrst_busy_low", 32'(busy),     32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        wait_frames("midrst_wait", exp_n + 1, 200);
        check_frame("midrst_resend", exp_n, 8'h0F);

        // Without the refresh feature nothing more is ever sent.
        repeat (600) @(posedge HCLK);
        check("no_refresh", 32'(frames.size()), 32'(exp_n + 1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_shift_driver.md
Name: led_shift_driver

Overview:
- Downstream consumer of the AHB-Lite LED register's 8-bit `led_out` value.
- Serialises the value onto an external 74HC595-style shift register using three pins: SER, SRCLK and RCLK.
- Sends a new frame only when the input value differs from the last value delivered, plus once after reset.
- Sits at the SoC top between the LED peripheral and the board pins, so board LEDs can sit behind a shift register.

Parameters:
- WIDTH, 8: number of LED bits in each frame.
- CLK_DIV, 4: HCLK cycles per shift-clock phase. Must be >= 1; each bit takes 2*CLK_DIV cycles.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
- REFRESH_CYCLES, 1000000: period of the periodic re-send. Used only when LED_SR_REFRESH_EN is defined.

Ports:
- HCLK  input  1  system clock; the only clock.
- HRESETn  input  1  asynchronous active-low reset.
- led_in  input  WIDTH  parallel LED value, driven by the `led_out` register; already synchronous to HCLK.
- sr_data  output  1  SER pin; serial data.
- sr_clk  output  1  SRCLK pin; the shift register samples on the rising edge.
- sr_latch  output  1  RCLK pin; a high pulse transfers the shift register to the LED outputs.
- busy  output  1  high while a frame is in flight.

Behaviour:
- Reset and output timing:
  - One clock, HCLK. Reset is asynchronous and active-low on HRESETn and applies to every flop.
  - Reset values: sr_data=0, sr_clk=0, sr_latch=0, busy=0, state=IDLE, sent_val=0, force_pending=1.
  - All outputs come straight from flops; there are no combinational paths to pins.
- Phase timer:
  - Counter phase_cnt runs 0..CLK_DIV-1.
  - phase_done = (phase_cnt==CLK_DIV-1). phase_cnt clears on every state change.
- State machine (one state transition per edge):
  - IDLE:
    - Start condition: (led_in != sent_val) or force_pending.
    - When it holds: shadow<=led_in, bit_cnt<=WIDTH-1, force_pending<=0, busy<=1, go to SETUP.
  - SETUP:
    - sr_clk=0; sr_data = shadow[bit index].
    - Bit index is WIDTH-1-bit_cnt' ordering per MSB_FIRST: MSB_FIRST=1 uses index bit_cnt; MSB_FIRST=0 uses index WIDTH-1-bit_cnt.
    - On phase_done, go to CLK_HI.
  - CLK_HI:
    - sr_clk=1; sr_data is held.
    - On phase_done: if bit_cnt==0 go to LATCH; else decrement bit_cnt and go to SETUP.
  - LATCH:
    - sr_clk=0, sr_latch=1.
    - On phase_done: sr_latch<=0, sent_val<=shadow, busy<=0, go to IDLE.
- Latency and frame length:
  - busy rises 1 cycle after led_in differs from sent_val while in IDLE.
  - busy stays high for exactly (2*WIDTH+1)*CLK_DIV cycles; with the defaults that is 68 cycles.
  - The earliest next frame starts on the cycle after busy falls.
- led_in changes during a frame:
  - They are ignored; shadow is frozen for the frame.
  - On return to IDLE the comparison runs again, so the newest value is always delivered eventually. Intermediate values may be skipped.
- Back-to-back frames: IDLE lasts at least 1 cycle between frames; sr_latch is low for that cycle.
- Reset mid-frame:
  - All outputs go low immediately.
  - force_pending=1 guarantees a full re-send after reset, even if led_in equals the reset value of sent_val.
- Values are transferred as-is; there is no arithmetic on them. bit_cnt is $clog2(WIDTH) bits wide and never wraps below 0.

Optional Feature:
- Macro: LED_SR_REFRESH_EN.
- Defined:
  - A free-running counter of REFRESH_CYCLES cycles sets force_pending on terminal count.
  - This re-sends the current value periodically, which recovers from glitches on the external register.
  - If the terminal count arrives during a frame, force_pending stays set and the re-send starts in the next IDLE.
  - The counter resets to 0.
- Not defined: no counter exists, and frames are sent only on a value change or after reset.

Decomposition:
- Shared package led_pkg:
  - State enum led_sr_state_t {IDLE, SETUP, CLK_HI, LATCH}.
  - Default constants LED_WIDTH=8 and LED_SR_CLK_DIV=4.
- One natural sub-module, led_sr_phase_timer: the CLK_DIV phase counter, with a clear input and a phase_done output. Everything else stays in the top module.

Test Plan:
- Reset release with led_in=8'h00 -> exactly one frame: 8 rising sr_clk edges all with sr_data=0, one sr_latch pulse of 4 cycles, busy high for 68 cycles.
- led_in=8'hA5 with MSB_FIRST=1 -> sr_data sampled at the sr_clk rising edges gives the sequence 1,0,1,0,0,1,0,1. The bench's model of the 595 shows 8'hA5 after sr_latch falls.
- Change led_in 8'h3C->8'hC3->8'hFF within the first 20 cycles of a frame -> the current frame completes unchanged, then exactly one more frame delivers 8'hFF.
- Write the same value as sent_val twice with the bus idle -> no frame; busy stays 0 and sr_clk shows no edges.
- Assert HRESETn=0 mid-SETUP of bit 3 -> sr_clk, sr_latch, sr_data and busy all go 0 asynchronously. After release, a full frame of the current led_in follows.
- With LED_SR_REFRESH_EN, REFRESH_CYCLES=200 and a constant led_in=8'h5A -> a frame of 8'h5A starts every 200 cycles. Without the macro, only the post-reset frame occurs.
